// File: rtl/generic_hscan_responder.sv
// generic_hscan_responder
//   Memory-backed slave for the generic_hscan bus. Accepts a request in IDLE,
//   then serves BURST beats of reads or writes against an internal word array,
//   optionally separating beats with WAIT_STATES stall cycles.
//
// Parameters
//   WIDTH        address/data width in bits (multiple of 8, >= 16)
//   DEPTH        memory words (power of 2, >= 2)
//   BASE         byte base address of the responder window
//   WAIT_STATES  STATUS-low cycles before every data beat (0..15)
//
// Ports
//   CLK       clock, all logic on posedge
//   RST_N     asynchronous active-low reset
//   CS        request strobe, sampled only in IDLE
//   CMD       1 = write, 0 = read
//   PRIORITY  accepted, ignored
//   BURST     beat count, 0 = null transaction
//   SIZE      log2 bytes per beat, only range-checked
//   ADDR      start byte address
//   wDATA     write data, consumed while STATUS = 1 in a write
//   rDATA     read data, valid while STATUS = 1 in a read
//   STATUS    registered beat acknowledge
//   BUSY      high from accept until the last beat edge
//   ERR       one-cycle pulse after accepting an out-of-window or bad-SIZE request
module generic_hscan_responder #(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       DEPTH       = 256,
    parameter logic [WIDTH-1:0]  BASE        = '0,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CS,
    input  logic             CMD,
    input  logic [7:0]       PRIORITY,
    input  logic [7:0]       BURST,
    input  logic [7:0]       SIZE,
    input  logic [WIDTH-1:0] ADDR,
    input  logic [WIDTH-1:0] wDATA,
    output logic [WIDTH-1:0] rDATA,
    output logic             STATUS,
    output logic             BUSY,
    output logic             ERR
);

    localparam int unsigned    BPW_LG    = $clog2(WIDTH / 8);
    localparam int unsigned    AW        = $clog2(DEPTH);
    localparam logic [WIDTH:0] WIN_BYTES = (WIDTH + 1)'(DEPTH * (WIDTH / 8));
    localparam logic [3:0]     WS_LAST   = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_NULL
    } state_t;

    state_t           state_q, state_d;
    logic             cmd_q, cmd_d;
    logic             inrange_q, inrange_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [7:0]       beats_q, beats_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             status_q, status_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] mem [DEPTH];

    // Request decode: byte offset into the window, word index, legality.
    logic [WIDTH:0]   offset;
    logic             addr_ok;
    logic             size_ok;
    logic [AW-1:0]    req_idx;
    logic             unused_inputs;

    assign offset        = {1'b0, ADDR} - {1'b0, BASE};
    assign addr_ok       = (ADDR >= BASE) && (offset < WIN_BYTES);
    assign size_ok       = (SIZE <= 8'(BPW_LG));
    assign req_idx       = offset[BPW_LG +: AW];
    assign unused_inputs = ^{PRIORITY, offset};

    // Read prefetch: rDATA is loaded at the edge that enters a read beat so it
    // is stable for the whole STATUS=1 cycle.
    logic             rd_load;
    logic             rd_ok;
    logic [AW-1:0]    rd_idx;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        inrange_d = inrange_q;
        idx_d     = idx_q;
        beats_d   = beats_q;
        wcnt_d    = wcnt_q;
        err_d     = 1'b0;
        rd_load   = 1'b0;
        rd_ok     = inrange_q;
        rd_idx    = idx_q;

        case (state_q)
            S_IDLE: begin
                if (CS) begin
                    cmd_d     = CMD;
                    beats_d   = BURST;
                    idx_d     = req_idx;
                    inrange_d = addr_ok;
                    wcnt_d    = WS_LAST;
                    err_d     = !addr_ok || !size_ok;
                    if (BURST == 8'd0) begin
                        state_d = S_NULL;
                    end else if (WAIT_STATES != 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DATA;
                        rd_load = !CMD;
                        rd_ok   = addr_ok;
                        rd_idx  = req_idx;
                    end
                end
            end
            S_NULL: begin
                state_d = S_IDLE;
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_DATA;
                    rd_load = !cmd_q;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_DATA: begin
                idx_d   = idx_q + 1'b1;
                beats_d = beats_q - 8'd1;
                if (beats_q == 8'd1) begin
                    state_d = S_IDLE;
                end else if (WAIT_STATES != 0) begin
                    state_d = S_WAIT;
                    wcnt_d  = WS_LAST;
                end else begin
                    rd_load = !cmd_q;
                    rd_idx  = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rdata_d  = rd_load ? (rd_ok ? mem[rd_idx] : '0) : rdata_q;
        status_d = (state_d == S_DATA);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cmd_q     <= 1'b0;
            inrange_q <= 1'b0;
            idx_q     <= '0;
            beats_q   <= '0;
            wcnt_q    <= '0;
            status_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            inrange_q <= inrange_d;
            idx_q     <= idx_d;
            beats_q   <= beats_d;
            wcnt_q    <= wcnt_d;
            status_q  <= status_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory is not reset; an async reset forces state_q out of S_DATA, so a
    // beat interrupted by reset never commits.
    always_ff @(posedge CLK) begin
        if (state_q == S_DATA && cmd_q && inrange_q) begin
            mem[idx_q] <= wDATA;
        end
    end

    assign rDATA  = rdata_q;
    assign STATUS = status_q;
    assign BUSY   = busy_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_generic_hscan_responder.sv
module tb_generic_hscan_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs0, cs2;
    logic        cmd;
    logic [7:0]  prio, burst, size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata2;
    logic        status0, status2, busy0, busy2, err0, err2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory image per DUT (index 0: WAIT_STATES=0, 1: WAIT_STATES=2)
    logic [31:0] mdl [2][256];

    always #5 clk = ~clk;

    generic_hscan_responder #(.WIDTH(32), .DEPTH(256), .BASE(32'h0), .WAIT_STATES(0)) u_ws0 (
        .CLK(clk), .RST_N(rst_n), .CS(cs0), .CMD(cmd), .PRIORITY(prio), .BURST(burst),
        .SIZE(size), .ADDR(addr), .wDATA(wdata), .rDATA(rdata0), .STATUS(status0),
        .BUSY(busy0), .ERR(err0)
    );

    generic_hscan_responder #(.WIDTH(32), .DEPTH(256), .BASE(32'h0), .WAIT_STATES(2)) u_ws2 (
        .CLK(clk), .RST_N(rst_n), .CS(cs2), .CMD(cmd), .PRIORITY(prio), .BURST(burst),
        .SIZE(size), .ADDR(addr), .wDATA(wdata), .rDATA(rdata2), .STATUS(status2),
        .BUSY(busy2), .ERR(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction on DUT d, checked cycle by cycle against the
    // rules: beat every (ws+1) cycles, BUSY for burst*(ws+1) cycles, ERR only
    // in the first cycle, out-of-window reads give 0 and writes are dropped.
    task automatic do_txn(input int d, input bit c_wr, input logic [31:0] a, input int b, input int sz);
        int          ws;
        bit          inr;
        bit          eerr;
        int          idx;
        int          n;
        bit          exp_st;
        logic        st, bz, er;
        logic [31:0] rd;
        ws   = (d == 0) ? 0 : 2;
        inr  = (a < 32'h400);
        eerr = !inr || (sz > 2);
        idx  = int'((a >> 2) % 256);
        n    = (b == 0) ? 1 : b * (ws + 1);

        @(negedge clk);
        cmd   = c_wr;
        addr  = a;
        burst = 8'(b);
        size  = 8'(sz);
        prio  = 8'($urandom);
        if (d == 0) cs0 = 1'b1; else cs2 = 1'b1;
        @(posedge clk);
        #1;
        cs0 = 1'b0;
        cs2 = 1'b0;

        for (int c = 1; c <= n; c++) begin
            wdata = $urandom;
            @(negedge clk);
            st = (d == 0) ? status0 : status2;
            bz = (d == 0) ? busy0   : busy2;
            er = (d == 0) ? err0    : err2;
            rd = (d == 0) ? rdata0  : rdata2;
            exp_st = (b != 0) && ((c % (ws + 1)) == 0);
            check("status", 32'(st), 32'(exp_st));
            check("busy", 32'(bz), 32'd1);
            check("err", 32'(er), (c == 1) ? 32'(eerr) : 32'd0);
            if (exp_st) begin
                if (c_wr) begin
                    if (inr) mdl[d][idx] = wdata;
                end else begin
                    check("rdata", rd, inr ? mdl[d][idx] : 32'd0);
                end
                idx = (idx + 1) % 256;
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        st = (d == 0) ? status0 : status2;
        bz = (d == 0) ? busy0   : busy2;
        er = (d == 0) ? err0    : err2;
        check("end_status", 32'(st), 32'd0);
        check("end_busy", 32'(bz), 32'd0);
        check("end_err", 32'(er), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cs0 = 1'b0; cs2 = 1'b0; cmd = 1'b0; prio = '0; burst = '0; size = '0;
        addr = '0; wdata = '0;
        #2;
        check("rst_status0", 32'(status0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_err0", 32'(err0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_status2", 32'(status2), 32'd0);
        check("rst_rdata2", rdata2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Give both memories a known image
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, 32'h000, 128, 2);
            do_txn(d, 1'b1, 32'h200, 128, 2);
        end

        // Burst write / read back, wait-state pattern, wrap, errors, null
        do_txn(0, 1'b1, 32'h010, 4, 2);
        do_txn(0, 1'b0, 32'h010, 4, 2);
        do_txn(1, 1'b0, 32'h010, 2, 2);
        do_txn(1, 1'b1, 32'h3FC, 2, 2);
        do_txn(0, 1'b1, 32'h3FC, 2, 2);
        do_txn(0, 1'b0, 32'h3FC, 2, 2);
        do_txn(0, 1'b0, 32'h400, 1, 2);
        do_txn(0, 1'b1, 32'h400, 2, 2);
        do_txn(0, 1'b1, 32'h020, 1, 3);
        do_txn(0, 1'b0, 32'h020, 1, 2);
        do_txn(0, 1'b1, 32'h040, 0, 2);
        do_txn(1, 1'b0, 32'h040, 0, 2);
        do_txn(1, 1'b0, 32'h3FC, 2, 2);

        // Reset in the middle of a 4-beat write, after two beats have landed
        @(negedge clk);
        cmd = 1'b1; addr = 32'h080; burst = 8'd4; size = 8'd2; cs0 = 1'b1;
        @(posedge clk);
        #1;
        cs0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wdata = $urandom;
            mdl[0][32 + k] = wdata;
            @(posedge clk);
            #1;
        end
        wdata = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_status", 32'(status0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_rdata", rdata0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 1'b0, 32'h080, 4, 2);

        // Randomized traffic on both responders
        for (int t = 0; t < 60; t++) begin
            int          d;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
            else                           a = 32'($urandom_range(0, 1023));
            do_txn(d, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
